// File: rtl/p4_instr_sequencer.sv
// Program-buffer sequencer feeding 16-bit instructions to the P4 CPU and
// capturing each result (out value and N/V/Z flags) into a one-cycle strobe.
module p4_instr_sequencer #(
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  input  logic          start,
  input  logic [AW:0]   num_instr,
  output logic [15:0]   cpu_in,
  output logic          cpu_load,
  output logic          cpu_s,
  input  logic          cpu_w,
  input  logic [15:0]   cpu_out,
  input  logic          cpu_N,
  input  logic          cpu_V,
  input  logic          cpu_Z,
  output logic          res_valid,
  output logic [15:0]   res_data,
  output logic [2:0]    res_flags,
  output logic [AW-1:0] res_index,
  output logic          busy,
  output logic          done,
  output logic          error
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, START, WAIT_LO, WAIT_HI, CAPTURE, FINISH
  } state_e;

  state_e        state, state_nxt;
  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] ptr, ptr_nxt;
  logic [AW:0]   cnt, cnt_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          err_nxt;
  logic          capture;
  logic          last;

  // Program buffer has no reset so its contents survive a mid-run abort.
  always_ff @(posedge clk) begin
    if (prog_we && state == IDLE)
      mem[prog_addr] <= prog_data;
  end

  assign cpu_in   = mem[ptr];
  assign cpu_load = (state == LOAD);
  assign cpu_s    = (state == START);
  assign busy     = (state != IDLE);
  assign done     = (state == FINISH);
  assign res_valid = (state == CAPTURE);
  assign last     = ({1'b0, ptr} == cnt - (AW+1)'(1));

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    timer_nxt = timer;
    err_nxt   = error;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          cnt_nxt   = (num_instr > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_instr;
          ptr_nxt   = '0;
          err_nxt   = 1'b0;
          state_nxt = (num_instr == '0) ? FINISH : LOAD;
        end
      end
      LOAD:  state_nxt = START;
      START: begin
        timer_nxt = '0;
        state_nxt = WAIT_LO;
      end
      WAIT_LO: begin
        if (!cpu_w) begin
          timer_nxt = '0;
          state_nxt = WAIT_HI;
        end else if (timer == TW'(1)) begin
          err_nxt   = 1'b1;
          state_nxt = FINISH;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      WAIT_HI: begin
        // Result fields are latched on the edge that enters CAPTURE so they
        // are already stable while res_valid is high.
        if (cpu_w) begin
          capture   = 1'b1;
          state_nxt = CAPTURE;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          err_nxt   = 1'b1;
          state_nxt = FINISH;
        end else begin
          timer_nxt = timer + TW'(1);
        end
      end
      CAPTURE: begin
        if (last) begin
          state_nxt = FINISH;
        end else begin
          ptr_nxt   = ptr + AW'(1);
          state_nxt = LOAD;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      timer     <= '0;
      error     <= 1'b0;
      res_data  <= '0;
      res_flags <= '0;
      res_index <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
      timer <= timer_nxt;
      error <= err_nxt;
      if (capture) begin
        res_data  <= cpu_out;
        res_flags <= {cpu_N, cpu_V, cpu_Z};
        res_index <= ptr;
      end
    end
  end

endmodule

// File: doc/p4_instr_sequencer.md
Name: p4_instr_sequencer

Overview:
- Sits directly upstream of the P4 RISC CPU and consumes its results.
- Holds a small program buffer of 16-bit instructions, written by the testbench or host.
- On start it feeds the instructions to the CPU one at a time. For each one it pulses load, then s, and waits for the CPU's w handshake to fall and rise again.
- It then captures the CPU's out value and N/V/Z flags into a one-cycle result strobe.

Parameters:
- DEPTH, 8, number of instruction slots in the program buffer (power of two).
- AW, 3, address width, log2(DEPTH).
- TIMEOUT, 16, maximum cycles to wait for w to return high before flagging an error.

Ports:
- clk  input  1  system clock; rising edge.
- reset  input  1  asynchronous, active-low reset.
- prog_we  input  1  program buffer write enable.
- prog_addr  input  AW  program buffer write address.
- prog_data  input  16  instruction to write.
- start  input  1  begin sequencing; sampled in IDLE only.
- num_instr  input  AW+1  instructions to run (0..DEPTH); sampled with start.
- cpu_in  output  16  instruction to the CPU in port.
- cpu_load  output  1  CPU instruction-register load.
- cpu_s  output  1  CPU start.
- cpu_w  input  1  CPU waiting flag.
- cpu_out  input  16  CPU datapath output.
- cpu_N, cpu_V, cpu_Z  input  1 each  CPU status flags.
- res_valid  output  1  one-cycle strobe; result fields valid.
- res_data  output  16  captured cpu_out.
- res_flags  output  3  captured {N,V,Z}.
- res_index  output  AW  buffer index of the instruction that produced the result.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle strobe at end of the program.
- error  output  1  sticky timeout flag; cleared by the next accepted start or by reset.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE and the pointer goes to 0.
  - All outputs go to 0: cpu_load, cpu_s, res_valid, res_data, res_flags, res_index, busy, done, error.
  - Program buffer contents are not cleared.
  - Reset mid-program abandons the sequence immediately. The CPU is not told, so the bench must also reset the CPU.
- Program writes: on a clock edge with prog_we=1 and busy=0, mem[prog_addr] <= prog_data. Writes while busy=1 are ignored.
- cpu_in = mem[ptr] combinationally in all states.
- FSM states: IDLE, LOAD, START, WAIT_LO, WAIT_HI, CAPTURE, FINISH.
  - IDLE: when start=1, latch cnt = min(num_instr, DEPTH), set ptr=0 and clear error.
    - If cnt=0, go to FINISH.
    - Otherwise go to LOAD.
  - LOAD: cpu_load=1 for exactly one cycle, then go to START.
  - START: cpu_s=1 for exactly one cycle, then go to WAIT_LO. The timer resets to 0.
  - WAIT_LO: wait for cpu_w=0.
    - If cpu_w stays 1 for 2 cycles, set error=1 and go to FINISH.
  - WAIT_HI: wait for cpu_w=1. The timer increments each cycle.
    - If the timer reaches TIMEOUT, set error=1 and go to FINISH.
  - CAPTURE:
    - res_valid=1 for one cycle, with res_data=cpu_out, res_flags={cpu_N,cpu_V,cpu_Z} and res_index=ptr. Fields are registered and hold until the next capture.
    - If ptr==cnt-1, go to FINISH. Otherwise ptr <= ptr+1 and go to LOAD.
  - FINISH: done=1 for one cycle, then go to IDLE.
- start while busy=1 is ignored. start and prog_we together in IDLE: the write happens and the run starts. Whether the run sees the new word is undefined, so the bench avoids it.
- ptr arithmetic is modulo DEPTH. With cnt=DEPTH the last index is DEPTH-1; no wrap occurs within a run.
- Per-instruction latency with a 4-state CPU sequence (DECODE, GETB, ADD, WRITE_REG):
  - LOAD, START, WAIT_LO (1 cycle), WAIT_HI (about 4 cycles), CAPTURE.
  - Total is 8–9 cycles, and 1 cycle more when the CPU opcode is 110.

Test Plan:
- Program mem[0]=16'hA0A4, num_instr=1, start; CPU model returns out=16'h0005 with N=0,V=0,Z=0 -> exactly one cpu_load pulse then one cpu_s pulse on the next cycle; res_valid once with res_data=16'h0005, res_flags=3'b000, res_index=0; done one cycle later; busy=0 afterwards.
- Program 3 slots, num_instr=3, CPU model returns out=0 with Z=1 on the second instruction -> res_index sequence 0,1,2; second result has res_flags=3'b001; done after the third; error=0.
- num_instr=0, start -> done within 2 cycles; no cpu_load, cpu_s or res_valid pulses.
- num_instr=12 with DEPTH=8 -> exactly 8 results, res_index 0..7; done asserted once.
- CPU model holds w=0 forever after s -> error=1 after TIMEOUT cycles in WAIT_HI; done pulses; busy returns to 0. The next start clears error.
- Drive reset=0 during WAIT_HI -> all outputs 0 asynchronously, before the next clock edge. Program buffer contents are preserved, so a rerun after release gives the same results. prog_we while busy leaves the buffer unchanged.
